// File: rtl/ard_link.sv
// Serial bridge between the CPU byte bus and the Arduino link: captures byte pairs,
// shifts them out MSB-first on a divided clock, and buffers received words as two bytes.
module ard_link #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned WORD_W  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bus_data,
   input  logic       bus_valid,
   input  logic       rx_pop,
   output logic [7:0] rx_byte,
   output logic       ard_receive_ready,
   output logic       ard_data_ready,
   output logic       link_err,
   input  logic       ard_rdy,
   output logic       ser_sclk,
   output logic       ser_sdo,
   input  logic       ser_rclk,
   input  logic       ser_sdi
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(WORD_W);

   typedef enum logic [1:0] {TX_IDLE, TX_LO, TX_SHIFT} tx_state_t;

   logic rdy_meta, rdy_sync;
   logic rclk_meta, rclk_sync, rclk_prev;
   logic sdi_meta, sdi_sync;
   logic rx_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_meta  <= 1'b0;
         rdy_sync  <= 1'b0;
         rclk_meta <= 1'b0;
         rclk_sync <= 1'b0;
         rclk_prev <= 1'b0;
         sdi_meta  <= 1'b0;
         sdi_sync  <= 1'b0;
      end else begin
         rdy_meta  <= ard_rdy;
         rdy_sync  <= rdy_meta;
         rclk_meta <= ser_rclk;
         rclk_sync <= rclk_meta;
         rclk_prev <= rclk_sync;
         sdi_meta  <= ser_sdi;
         sdi_sync  <= sdi_meta;
      end
   end

   assign rx_edge = rclk_sync & ~rclk_prev;

   // ---------------- TX ----------------
   tx_state_t         tx_state, tx_state_nxt;
   logic [7:0]        hi_byte, hi_byte_nxt;
   logic [WORD_W-1:0] word, word_nxt;
   logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
   logic [DIV_W-1:0]  divcnt, divcnt_nxt;
   logic              sclk_nxt, sdo_nxt, tx_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         hi_byte  <= '0;
         word     <= '0;
         bitcnt   <= '0;
         divcnt   <= '0;
         ser_sclk <= 1'b0;
         ser_sdo  <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         hi_byte  <= hi_byte_nxt;
         word     <= word_nxt;
         bitcnt   <= bitcnt_nxt;
         divcnt   <= divcnt_nxt;
         ser_sclk <= sclk_nxt;
         ser_sdo  <= sdo_nxt;
      end
   end

   // The word is held static and bits are selected by bitcnt instead of shifted out.
   always_comb begin
      tx_state_nxt = tx_state;
      hi_byte_nxt  = hi_byte;
      word_nxt     = word;
      bitcnt_nxt   = bitcnt;
      divcnt_nxt   = divcnt;
      sclk_nxt     = ser_sclk;
      sdo_nxt      = ser_sdo;
      tx_err       = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (bus_valid) begin
               hi_byte_nxt  = bus_data;
               tx_state_nxt = TX_LO;
            end
         end
         TX_LO: begin
            if (bus_valid) begin
               word_nxt     = {hi_byte, bus_data};
               bitcnt_nxt   = CNT_W'(WORD_W - 1);
               divcnt_nxt   = '0;
               sclk_nxt     = 1'b0;
               sdo_nxt      = hi_byte[7];
               tx_state_nxt = TX_SHIFT;
            end else begin
               tx_err       = 1'b1;
               tx_state_nxt = TX_IDLE;
            end
         end
         TX_SHIFT: begin
            tx_err = bus_valid;
            if (divcnt == DIV_W'(CLK_DIV - 1)) begin
               divcnt_nxt = '0;
               if (!ser_sclk) begin
                  sclk_nxt = 1'b1;
               end else begin
                  sclk_nxt = 1'b0;
                  if (bitcnt != '0) begin
                     bitcnt_nxt = bitcnt - 1'b1;
                     sdo_nxt    = word[bitcnt_nxt];
                  end else begin
                     sdo_nxt      = 1'b0;
                     tx_state_nxt = TX_IDLE;
                  end
               end
            end else begin
               divcnt_nxt = divcnt + 1'b1;
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // ---------------- RX ----------------
   logic [WORD_W-2:0] rx_sh;
   logic [WORD_W-1:0] rx_word, rx_buf;
   logic [CNT_W-1:0]  rcnt;
   logic              rx_full, rx_ptr, rx_done, rx_free, rx_ovr;

   assign rx_word = {rx_sh, sdi_sync};
   assign rx_done = rx_edge && (rcnt == '1);
   // A second pop landing with word completion frees the buffer in the same cycle.
   assign rx_free = ~rx_full | (rx_pop & rx_ptr);
   assign rx_ovr  = rx_done & ~rx_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh   <= '0;
         rcnt    <= '0;
         rx_buf  <= '0;
         rx_full <= 1'b0;
         rx_ptr  <= 1'b0;
      end else begin
         if (rx_edge) begin
            rx_sh <= rx_word[WORD_W-2:0];
            rcnt  <= rcnt + 1'b1;
         end
         if (rx_done && rx_free) begin
            rx_buf  <= rx_word;
            rx_full <= 1'b1;
            rx_ptr  <= 1'b0;
         end else if (rx_pop && rx_full) begin
            if (!rx_ptr) rx_ptr  <= 1'b1;
            else         rx_full <= 1'b0;
         end
      end
   end

   assign ard_data_ready = rx_full;
   assign rx_byte = rx_full ? (rx_ptr ? rx_buf[7:0] : rx_buf[15:8]) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ard_receive_ready <= 1'b0;
         link_err          <= 1'b0;
      end else begin
         ard_receive_ready <= rdy_sync & (tx_state == TX_IDLE) & ~bus_valid;
         link_err          <= tx_err | rx_ovr;
      end
   end

endmodule

// File: tb/tb_ard_link.sv
// Scoreboard bench for ard_link: expected TX words and RX bytes are queued at
// stimulus time; independent monitors compare what the link actually produces.
module tb_ard_link;

   localparam int unsigned TB_DIV = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] bus_data;
   logic       bus_valid;
   logic       rx_pop;
   logic [7:0] rx_byte;
   logic       ard_receive_ready;
   logic       ard_data_ready;
   logic       link_err;
   logic       ard_rdy;
   logic       ser_sclk;
   logic       ser_sdo;
   logic       ser_rclk;
   logic       ser_sdi;

   ard_link #(.CLK_DIV(TB_DIV), .WORD_W(16)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus_data          (bus_data),
      .bus_valid         (bus_valid),
      .rx_pop            (rx_pop),
      .rx_byte           (rx_byte),
      .ard_receive_ready (ard_receive_ready),
      .ard_data_ready    (ard_data_ready),
      .link_err          (link_err),
      .ard_rdy           (ard_rdy),
      .ser_sclk          (ser_sclk),
      .ser_sdo           (ser_sdo),
      .ser_rclk          (ser_rclk),
      .ser_sdi           (ser_sdi)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] tx_exp[$];
   logic [7:0]  rx_exp[$];
   int          err_exp = 0;
   int          err_cnt = 0;
   logic        pop_en = 1'b1;
   logic        rx_pending = 1'b0;
   int unsigned rx_rise_cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_tx(input logic [15:0] w);
      int unsigned n = 0;
      while (!ard_receive_ready && n < 1000) begin
         tick(1);
         n++;
      end
      if (!ard_receive_ready) begin
         fail("tx_ready_wait");
         return;
      end
      tx_exp.push_back(w);
      bus_data  = w[15:8];
      bus_valid = 1'b1;
      tick(1);
      bus_data  = w[7:0];
      tick(1);
      bus_valid = 1'b0;
   endtask

   // Arduino side: 10-clk rclk period, data set while rclk is low.
   task automatic send_rx_bits(input logic [15:0] w, input int unsigned nbits);
      for (int unsigned i = 0; i < nbits; i++) begin
         ser_sdi  = w[15 - i];
         ser_rclk = 1'b0;
         tick(5);
         ser_rclk = 1'b1;
         if (i == 15) begin
            // A word arriving while an unread word is still held is lost as an overrun.
            if (!pop_en && rx_exp.size() != 0) begin
               err_exp++;
            end else begin
               rx_exp.push_back(w[15:8]);
               rx_exp.push_back(w[7:0]);
               rx_pending  = 1'b1;
               rx_rise_cyc = cyc;
            end
         end
         tick(5);
      end
      ser_rclk = 1'b0;
   endtask

   task automatic wait_tx_done();
      int unsigned n = 0;
      while (!(tx_exp.size() == 0 && ard_receive_ready) && n < 1000) begin
         tick(1);
         n++;
      end
      if (n >= 1000) fail("tx_done_wait");
   endtask

   task automatic wait_rx_drained();
      int unsigned n = 0;
      while (!(rx_exp.size() == 0 && !ard_data_ready) && n < 400) begin
         tick(1);
         n++;
      end
      if (n >= 400) fail("rx_drain_wait");
   endtask

   task automatic check_all_zero(input string name);
      check(name, {18'd0, ser_sclk, ser_sdo, ard_receive_ready, ard_data_ready, link_err, 1'b0, rx_byte}, 32'd0);
   endtask

   // TX monitor: rebuilds each word from sdo at sclk rising edges.
   initial begin : tx_mon
      logic [15:0] acc = '0;
      int unsigned nb = 0, hi_len = 0, after = 0;
      logic        prev = 1'b0, arr_bad = 1'b0;
      logic [15:0] expw;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            nb = 0; hi_len = 0; after = 0; prev = 1'b0; arr_bad = 1'b0;
         end else begin
            if (after > 0) begin
               if (ard_receive_ready) begin
                  check("tx_ready_after_word", 32'(ard_receive_ready), 32'd1);
                  after = 0;
               end else if (after == 3) begin
                  fail("tx_ready_after_word");
                  after = 0;
               end else begin
                  after++;
               end
            end
            if (ser_sclk && !prev) begin
               acc = {acc[14:0], ser_sdo};
               nb++;
               hi_len = 1;
            end else if (ser_sclk) begin
               hi_len++;
            end else if (prev) begin
               check("sclk_high_len", hi_len, TB_DIV);
               if (nb == 16) begin
                  check("sdo_idle_after_word", 32'(ser_sdo), 32'd0);
                  check("ready_low_during_word", 32'(arr_bad), 32'd0);
                  if (tx_exp.size() == 0) begin
                     check("tx_unexpected_word", 32'(acc), 32'hFFFF_FFFF);
                  end else begin
                     expw = tx_exp.pop_front();
                     check("tx_word", 32'(acc), 32'(expw));
                  end
                  nb = 0;
                  arr_bad = 1'b0;
                  after = 1;
               end
            end
            if ((ser_sclk || nb > 0) && ard_receive_ready) arr_bad = 1'b1;
            prev = ser_sclk;
         end
      end
   end

   // RX monitor: consumes bytes whenever the link holds data and popping is enabled.
   initial begin : rx_mon
      logic       prev_rdy = 1'b0, chk_drop = 1'b0;
      logic [7:0] expb;
      rx_pop = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rx_pop = 1'b0;
         if (!rst_n) begin
            prev_rdy = 1'b0;
            chk_drop = 1'b0;
         end else begin
            if (rx_pending && ard_data_ready && !prev_rdy) begin
               check("rx_ready_latency_le4", 32'(cyc - rx_rise_cyc <= 4), 32'd1);
               rx_pending = 1'b0;
            end
            if (chk_drop) begin
               check("rx_ready_after_pops", 32'(ard_data_ready), 32'(rx_exp.size() != 0));
               chk_drop = 1'b0;
            end
            if (pop_en && ard_data_ready) begin
               if (rx_exp.size() == 0) begin
                  check("rx_unexpected_byte", 32'(rx_byte), 32'hFFFF_FFFF);
               end else begin
                  chk_drop = (rx_exp.size() % 2 == 1);
                  expb = rx_exp.pop_front();
                  check("rx_byte", 32'(rx_byte), 32'(expb));
               end
               rx_pop = 1'b1;
            end
            prev_rdy = ard_data_ready;
         end
      end
   end

   initial begin : err_mon
      forever begin
         @(negedge clk);
         if (rst_n && link_err) err_cnt++;
      end
   end

   initial begin : main
      logic [7:0]  b;
      int unsigned n;
      logic        bad;
      rst_n = 1'b0; bus_data = '0; bus_valid = 1'b0; ard_rdy = 1'b1;
      ser_rclk = 1'b0; ser_sdi = 1'b0;
      tick(3);
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      tick(4);

      // Fixed TX word, then fixed RX word.
      send_tx(16'hBEEF);
      wait_tx_done();
      send_rx_bits(16'h1234, 16);
      wait_rx_drained();
      check("err_after_basic", err_cnt, err_exp);

      // Overrun: first word held unread, second word dropped.
      pop_en = 1'b0;
      send_rx_bits(16'hAAAA, 16);
      tick(5);
      send_rx_bits(16'h5555, 16);
      tick(5);
      check("overrun_rx_byte_kept", 32'(rx_byte), 32'hAA);
      check("overrun_ready_kept", 32'(ard_data_ready), 32'd1);
      check("overrun_err", err_cnt, err_exp);
      pop_en = 1'b1;
      wait_rx_drained();

      // Half word: one bus_valid cycle then idle.
      b = 8'($urandom);
      bus_data = b; bus_valid = 1'b1;
      tick(1);
      bus_valid = 1'b0;
      tick(1);
      check("half_word_err_pulse", 32'(link_err), 32'd1);
      err_exp++;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ser_sclk) bad = 1'b1;
         tick(1);
      end
      check("half_word_no_sclk", 32'(bad), 32'd0);
      check("half_word_ready_back", 32'(ard_receive_ready), 32'd1);
      check("half_word_err", err_cnt, err_exp);

      // bus_valid during shifting is ignored but flagged.
      send_tx(16'($urandom));
      tick(10);
      bus_data = 8'($urandom); bus_valid = 1'b1;
      tick(1);
      bus_valid = 1'b0;
      err_exp++;
      wait_tx_done();
      check("busy_valid_err", err_cnt, err_exp);

      // Concurrent random traffic, with ard_rdy dipping mid-word.
      fork
         begin
            for (int i = 0; i < 4; i++) send_tx(16'($urandom));
         end
         begin
            for (int i = 0; i < 4; i++) begin
               send_rx_bits(16'($urandom), 16);
               tick($urandom_range(3, 30));
            end
         end
         begin
            tick(30);
            ard_rdy = 1'b0;
            tick(8);
            ard_rdy = 1'b1;
         end
      join
      wait_tx_done();
      wait_rx_drained();
      check("random_err", err_cnt, err_exp);

      // Mid-operation reset: partial RX and partial TX discarded.
      send_rx_bits(16'($urandom), 7);
      send_tx(16'($urandom));
      tick(5 * 2 * TB_DIV);
      rst_n = 1'b0;
      tx_exp.delete();
      rx_pending = 1'b0;
      #1;
      check_all_zero("midop_reset_outputs");
      tick(3);
      rst_n = 1'b1;
      tick(2);
      send_tx(16'h00FF);
      send_rx_bits(16'hC3C3, 16);
      wait_tx_done();
      wait_rx_drained();
      check("post_reset_err", err_cnt, err_exp);

      // ard_rdy low holds off the ready indication.
      ard_rdy = 1'b0;
      tick(3);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ard_receive_ready) bad = 1'b1;
         tick(1);
      end
      check("rdy_low_ready_low", 32'(bad), 32'd0);
      ard_rdy = 1'b1;
      n = 0;
      while (!ard_receive_ready && n < 3) begin
         tick(1);
         n++;
      end
      check("rdy_rise_ready_within3", 32'(ard_receive_ready), 32'd1);

      tick(10);
      check("final_err", err_cnt, err_exp);
      check("final_tx_queue", tx_exp.size(), 32'd0);
      check("final_rx_queue", rx_exp.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

endmodule
